// File: rtl/tag_alloc16.sv
// ---------------------------------------------------------------------------
// tag_alloc16
//   Sixteen-entry round-robin tag allocator. Hands out one 4-bit tag per
//   cycle (plus its one-hot decode) to a single requester and accepts one
//   released tag per cycle. A flush returns the free vector to INIT_FREE.
//
// Parameters
//   INIT_FREE    : free-vector value at reset and after flush (1 = free)
//
// Ports
//   clk          : clock, rising edge
//   rst_aL       : asynchronous active-low reset
//   alloc_req    : requester wants a tag this cycle
//   alloc_ready  : at least one tag is free
//   alloc_tag    : tag offered this cycle (0 when none free)
//   alloc_onehot : one-hot decode of alloc_tag (0 when none free)
//   rel_valid    : release a tag this cycle
//   rel_tag      : tag being released
//   flush        : return every outstanding tag (highest priority)
//   free_vec     : registered free vector
//   free_cnt     : number of free tags, 0..16
//   err          : sticky double-release flag
//
// Build option
//   TAG_ALLOC_ERRCHK_EN : when defined, a double release sets err until
//                         reset; otherwise err is tied low.
// ---------------------------------------------------------------------------
module tag_alloc16 #(
    parameter logic [15:0] INIT_FREE = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_aL,
    input  logic        alloc_req,
    output logic        alloc_ready,
    output logic [3:0]  alloc_tag,
    output logic [15:0] alloc_onehot,
    input  logic        rel_valid,
    input  logic [3:0]  rel_tag,
    input  logic        flush,
    output logic [15:0] free_vec,
    output logic [4:0]  free_cnt,
    output logic        err
);

    localparam logic [4:0] INIT_CNT = 5'($countones(INIT_FREE));

    logic [15:0] free_q, free_d;
    logic [3:0]  ptr_q,  ptr_d;
    logic [4:0]  cnt_q,  cnt_d;

    logic        sel_found;
    logic [3:0]  sel_tag;
    logic [3:0]  scan_idx;
    logic        fire;
    logic [15:0] rel_onehot;
    logic        rel_dup;
    logic        rel_ok;

    // Round-robin search: first free tag at ptr_q, ptr_q+1, ... modulo 16.
    always_comb begin
        sel_found = 1'b0;
        sel_tag   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            scan_idx = ptr_q + 4'(i);
            if (!sel_found && free_q[scan_idx]) begin
                sel_found = 1'b1;
                sel_tag   = scan_idx;
            end
        end
    end

    assign alloc_ready  = (cnt_q != 5'd0);
    assign alloc_tag    = alloc_ready ? sel_tag : 4'd0;
    assign alloc_onehot = alloc_ready ? (16'h0001 << sel_tag) : '0;

    assign fire       = alloc_req && alloc_ready;
    assign rel_onehot = 16'h0001 << rel_tag;
    // Judged against the pre-edge free vector, so releasing the tag that is
    // being allocated in the same cycle counts as a double release.
    assign rel_dup    = |(free_q & rel_onehot);
    assign rel_ok     = rel_valid && !rel_dup;

    always_comb begin
        free_d = free_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            free_d = INIT_FREE;
            cnt_d  = INIT_CNT;
        end else begin
            if (fire) begin
                free_d = free_d & ~alloc_onehot;
                ptr_d  = alloc_tag + 4'd1;
            end
            if (rel_ok) begin
                free_d = free_d | rel_onehot;
            end
            case ({fire, rel_ok})
                2'b10:   cnt_d = cnt_q - 5'd1;
                2'b01:   cnt_d = cnt_q + 5'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            free_q <= INIT_FREE;
            ptr_q  <= '0;
            cnt_q  <= INIT_CNT;
        end else begin
            free_q <= free_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign free_vec = free_q;
    assign free_cnt = cnt_q;

`ifdef TAG_ALLOC_ERRCHK_EN
    logic err_q, err_d;

    // A release swallowed by flush is not a double release.
    always_comb begin
        err_d = err_q | (rel_valid && rel_dup && !flush);
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_alloc16.sv
module tb_tag_alloc16;

    logic        clk;
    logic        rst_aL;
    logic        alloc_req;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic [15:0] alloc_onehot;
    logic        rel_valid;
    logic [3:0]  rel_tag;
    logic        flush;
    logic [15:0] free_vec;
    logic [4:0]  free_cnt;
    logic        err;

`ifdef TAG_ALLOC_ERRCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    tag_alloc16 #(.INIT_FREE(16'hFFFF)) dut (
        .clk          (clk),
        .rst_aL       (rst_aL),
        .alloc_req    (alloc_req),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .alloc_onehot (alloc_onehot),
        .rel_valid    (rel_valid),
        .rel_tag      (rel_tag),
        .flush        (flush),
        .free_vec     (free_vec),
        .free_cnt     (free_cnt),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake that fires must match the next queued tag.
    always @(negedge clk) begin
        logic [3:0]  e;
        logic [15:0] e_oh;
        if (rst_aL && alloc_req && alloc_ready && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_alloc: got tag %0d expected no allocation", alloc_tag);
            end else begin
                e    = exp_q.pop_front();
                e_oh = 16'h0001 << e;
                if (alloc_tag !== e || alloc_onehot !== e_oh) begin
                    errors++;
                    $display("FAIL alloc_tag: got %0d/%04h expected %0d/%04h",
                             alloc_tag, alloc_onehot, e, e_oh);
                end
            end
        end
    end

    task automatic alloc_n(input int n);
        @(posedge clk); #1;
        alloc_req = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        alloc_req = 1'b0;
    endtask

    task automatic release_tag(input logic [3:0] t);
        @(posedge clk); #1;
        rel_valid = 1'b1;
        rel_tag   = t;
        @(posedge clk); #1;
        rel_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] fv, input logic [4:0] fc,
                             input logic rdy, input logic [3:0] t, input logic [15:0] oh);
        chk({tag, "_free_vec"}, 32'(free_vec), 32'(fv));
        chk({tag, "_free_cnt"}, 32'(free_cnt), 32'(fc));
        chk({tag, "_ready"},    32'(alloc_ready), 32'(rdy));
        chk({tag, "_tag"},      32'(alloc_tag), 32'(t));
        chk({tag, "_onehot"},   32'(alloc_onehot), 32'(oh));
    endtask

    // Reset asserted between edges; outputs must settle before the next edge.
    task automatic async_reset(input string tag);
        @(posedge clk); #2;
        rst_aL = 1'b0;
        #1;
        chk_state(tag, 16'hFFFF, 5'd16, 1'b1, 4'd0, 16'h0001);
        chk({tag, "_err"}, 32'(err), 32'd0);
        @(negedge clk);
        rst_aL = 1'b1;
    endtask

    initial begin
        rst_aL    = 1'b0;
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        rel_tag   = 4'd0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        chk_state("reset", 16'hFFFF, 5'd16, 1'b1, 4'd0, 16'h0001);
        chk("reset_err", 32'(err), 32'd0);
        rst_aL = 1'b1;

        // Fill: tags 0..15 in order, then empty.
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        alloc_n(16);
        @(negedge clk);
        chk_state("empty", 16'h0000, 5'd0, 1'b0, 4'd0, 16'h0000);

        // Release while empty with a request: no allocation, tag 5 next cycle.
        @(posedge clk); #1;
        rel_valid = 1'b1;
        rel_tag   = 4'd5;
        alloc_req = 1'b1;
        @(posedge clk); #1;
        rel_valid = 1'b0;
        alloc_req = 1'b0;
        @(negedge clk);
        chk_state("simul", 16'h0020, 5'd1, 1'b1, 4'd5, 16'h0020);
        exp_q.push_back(4'd5);
        alloc_n(1);
        @(negedge clk);
        chk("simul_cnt", 32'(free_cnt), 32'd0);

        async_reset("arst1");

        // Round-robin wrap: 0..9, release 3, then 10..15 before 3.
        for (int i = 0; i < 10; i++) exp_q.push_back(4'(i));
        alloc_n(10);
        release_tag(4'd3);
        @(negedge clk);
        chk_state("rr", 16'hFC08, 5'd7, 1'b1, 4'd10, 16'h0400);
        for (int i = 10; i < 16; i++) exp_q.push_back(4'(i));
        exp_q.push_back(4'd3);
        alloc_n(7);
        @(negedge clk);
        chk("rr_cnt", 32'(free_cnt), 32'd0);

        // Alloc and release of different tags in one cycle (ptr now 4).
        release_tag(4'd0);
        @(posedge clk); #1;
        exp_q.push_back(4'd0);
        alloc_req = 1'b1;
        rel_valid = 1'b1;
        rel_tag   = 4'd1;
        @(posedge clk); #1;
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        @(negedge clk);
        chk_state("ar_same", 16'h0002, 5'd1, 1'b1, 4'd1, 16'h0002);

        // Flush priority with six tags outstanding.
        @(negedge clk);
        rst_aL = 1'b0;
        @(negedge clk);
        rst_aL = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(4'(i));
        alloc_n(6);
        @(posedge clk); #1;
        flush     = 1'b1;
        alloc_req = 1'b1;
        rel_valid = 1'b1;
        rel_tag   = 4'd2;
        @(posedge clk); #1;
        flush     = 1'b0;
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        @(negedge clk);
        chk_state("flush", 16'hFFFF, 5'd16, 1'b1, 4'd6, 16'h0040);
        chk("flush_err", 32'(err), 32'd0);

        // Double release of a free tag while not full.
        exp_q.push_back(4'd6);
        alloc_n(1);
        release_tag(4'd7);
        @(negedge clk);
        chk_state("dbl", 16'hFFBF, 5'd15, 1'b1, 4'd7, 16'h0080);
        chk("dbl_err", 32'(err), 32'(ERR_EXP));

        // err survives flush; release while full is also a double release.
        pulse_flush();
        @(negedge clk);
        chk("dbl_flush_cnt", 32'(free_cnt), 32'd16);
        chk("dbl_flush_err", 32'(err), 32'(ERR_EXP));
        release_tag(4'd0);
        @(negedge clk);
        chk("full_rel_cnt", 32'(free_cnt), 32'd16);
        chk("full_rel_vec", 32'(free_vec), 32'hFFFF);

        // Reset clears err.
        async_reset("arst2");

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
